// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder definitions: DC stage state encoding, size limits and
// the EXTEND sign-recovery helper.
package jpeg_dec_pkg;

  localparam int unsigned MAX_DC_SIZE    = 11;
  localparam int unsigned COEF_W_DEFAULT = 12;
  localparam int unsigned SIZE_W         = 4;
  localparam int unsigned COMP_W         = 2;
  localparam int unsigned DIFF_W         = MAX_DC_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AMP  = 2'd1,
    ST_OUT  = 2'd2
  } dc_state_e;

  // JPEG EXTEND: a leading 0 amplitude bit marks a negative difference.
  function automatic logic signed [DIFF_W-1:0] extend(
    input logic [MAX_DC_SIZE-1:0] amp,
    input logic [SIZE_W-1:0]      size
  );
    logic [DIFF_W-1:0] a;
    logic [DIFF_W-1:0] m;
    logic              msb;
    a   = {1'b0, amp};
    m   = (DIFF_W'(1) << size) - DIFF_W'(1);
    msb = amp[size - SIZE_W'(1)];
    if (size == '0) begin
      return '0;
    end
    return msb ? $signed(a) : $signed(a - m);
  endfunction

endpackage

// File: rtl/dc_predictor_bank.sv
// Per-component DPCM predictor registers with indexed read; clear-all wins
// over a simultaneous write.
module dc_predictor_bank
  import jpeg_dec_pkg::*;
#(
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned COEF_W   = COEF_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic [COMP_W-1:0]        i_rd_idx,
  output logic signed [COEF_W-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [COMP_W-1:0]        i_wr_idx,
  input  logic signed [COEF_W-1:0] i_wr_data
);

  logic signed [COEF_W-1:0] r_pred [NUM_COMP];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < int'(NUM_COMP); i++) r_pred[i] <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < int'(NUM_COMP); i++) begin
        if (32'(i_wr_idx) == 32'(i)) r_pred[i] <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < int'(NUM_COMP); i++) begin
      if (32'(i_rd_idx) == 32'(i)) o_rd_data = r_pred[i];
    end
  end

endmodule

// File: rtl/dc_diff_decoder.sv
// DC difference decoder: reads the amplitude bits for a DC size category,
// applies EXTEND, adds the component predictor and hands the DC value on.
module dc_diff_decoder
  import jpeg_dec_pkg::*;
#(
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned COEF_W   = COEF_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SIZE_W-1:0]        size_in,
  input  logic [COMP_W-1:0]        comp_in,
  input  logic                     size_valid,
  output logic                     size_ready,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic                     pred_clear,
  output logic signed [COEF_W-1:0] coeff_out,
  output logic [COMP_W-1:0]        coeff_comp,
  output logic                     coeff_valid,
  input  logic                     coeff_ready,
  output logic                     size_err
);

  dc_state_e                r_state;
  logic [SIZE_W-1:0]        r_size;
  logic [COMP_W-1:0]        r_comp;
  logic [MAX_DC_SIZE-1:0]   r_amp;
  logic [SIZE_W-1:0]        r_cnt;
  logic                     r_size_ready;
  logic                     r_bit_ready;
  logic                     r_coeff_valid;
  logic signed [COEF_W-1:0] r_coeff_out;
  logic [COMP_W-1:0]        r_coeff_comp;
  logic                     r_size_err;

  logic [COMP_W-1:0]        w_comp;
  logic [COMP_W-1:0]        w_rd_idx;
  logic signed [COEF_W-1:0] w_rd_data;
  logic signed [COEF_W-1:0] w_pred;
  logic [MAX_DC_SIZE-1:0]   w_amp_nxt;
  logic [SIZE_W-1:0]        w_cnt_nxt;
  logic signed [COEF_W-1:0] w_diff;
  logic                     w_size_bad;
  logic                     w_hs;

  // Out-of-range component indices alias to component 0.
  assign w_comp     = (32'(comp_in) < NUM_COMP) ? comp_in : COMP_W'(0);
  assign w_rd_idx   = (r_state == ST_IDLE) ? w_comp : r_comp;
  assign w_pred     = pred_clear ? '0 : w_rd_data;
  assign w_amp_nxt  = {r_amp[MAX_DC_SIZE-2:0], bit_in};
  assign w_cnt_nxt  = r_cnt + SIZE_W'(1);
  assign w_diff     = COEF_W'(extend(w_amp_nxt, r_size));
  assign w_size_bad = size_in > SIZE_W'(MAX_DC_SIZE);
  assign w_hs       = r_coeff_valid && coeff_ready;

  dc_predictor_bank #(
    .NUM_COMP (NUM_COMP),
    .COEF_W   (COEF_W)
  ) u_pred (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (pred_clear),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_hs),
    .i_wr_idx  (r_coeff_comp),
    .i_wr_data (r_coeff_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_size        <= '0;
      r_comp        <= '0;
      r_amp         <= '0;
      r_cnt         <= '0;
      r_size_ready  <= 1'b1;
      r_bit_ready   <= 1'b0;
      r_coeff_valid <= 1'b0;
      r_coeff_out   <= '0;
      r_coeff_comp  <= '0;
      r_size_err    <= 1'b0;
    end else begin
      if (pred_clear) r_size_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (size_valid) begin
            r_size       <= size_in;
            r_comp       <= w_comp;
            r_amp        <= '0;
            r_cnt        <= '0;
            r_size_ready <= 1'b0;
            // Size 0 and illegal sizes carry no amplitude bits.
            if (size_in == '0 || w_size_bad) begin
              r_coeff_out   <= w_pred;
              r_coeff_comp  <= w_comp;
              r_coeff_valid <= 1'b1;
              r_state       <= ST_OUT;
              if (w_size_bad && !pred_clear) r_size_err <= 1'b1;
            end else begin
              r_bit_ready <= 1'b1;
              r_state     <= ST_AMP;
            end
          end
        end
        ST_AMP: begin
          if (bit_valid) begin
            r_amp <= w_amp_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_size) begin
              r_bit_ready   <= 1'b0;
              r_coeff_out   <= w_pred + w_diff;
              r_coeff_comp  <= r_comp;
              r_coeff_valid <= 1'b1;
              r_state       <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (coeff_ready) begin
            r_coeff_valid <= 1'b0;
            r_size_ready  <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_size_ready  <= 1'b1;
          r_bit_ready   <= 1'b0;
          r_coeff_valid <= 1'b0;
        end
      endcase
    end
  end

  assign size_ready  = r_size_ready;
  assign bit_ready   = r_bit_ready;
  assign coeff_valid = r_coeff_valid;
  assign coeff_out   = r_coeff_out;
  assign coeff_comp  = r_coeff_comp;
  assign size_err    = r_size_err;

endmodule

// File: tb/tb_dc_diff_decoder.sv
// Self-checking bench for dc_diff_decoder against an arithmetic model of
// JPEG DC difference decoding with per-component predictors.
module tb_dc_diff_decoder;

  localparam int unsigned NC = 3;
  localparam int unsigned CW = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           size_in;
  logic [1:0]           comp_in;
  logic                 size_valid;
  logic                 size_ready;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 pred_clear;
  logic signed [CW-1:0] coeff_out;
  logic [1:0]           coeff_comp;
  logic                 coeff_valid;
  logic                 coeff_ready;
  logic                 size_err;

  int checks = 0;
  int errors = 0;

  logic signed [CW-1:0] mpred [NC];
  logic                 merr;

  dc_diff_decoder #(.NUM_COMP(NC), .COEF_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .size_in     (size_in),
    .comp_in     (comp_in),
    .size_valid  (size_valid),
    .size_ready  (size_ready),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .pred_clear  (pred_clear),
    .coeff_out   (coeff_out),
    .coeff_comp  (coeff_comp),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .size_err    (size_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NC); i++) mpred[i] = '0;
    merr = 1'b0;
  endtask

  // Reference: value = amp if its top bit is set, else amp - (2^size - 1).
  function automatic logic signed [CW-1:0] model_coeff(input logic signed [CW-1:0] p,
                                                       input int size, input int amp);
    int diff;
    if (size == 0) diff = 0;
    else if (amp >= (1 << (size - 1))) diff = amp;
    else diff = amp - ((1 << size) - 1);
    return CW'(int'(p) + diff);
  endfunction

  // clr_mode: 0 none, 1 pred_clear on the output handshake, 2 pred_clear during AMP
  task automatic run_block(input int size, input int comp, input int amp_in,
                           input bit gaps, input int bp, input int clr_mode);
    int esize, ecomp, amp;
    logic signed [CW-1:0] exp;
    esize = (size > 11) ? 0 : size;
    ecomp = (comp >= int'(NC)) ? 0 : comp;
    amp   = (esize == 0) ? 0 : (amp_in & ((1 << esize) - 1));
    checks++;
    if ({size_ready, bit_ready, coeff_valid} !== 3'b100) begin
      errors++;
      $display("FAIL idle_flags got %b want 100", {size_ready, bit_ready, coeff_valid});
    end
    size_in = 4'(size); comp_in = 2'(comp); size_valid = 1'b1;
    tick();
    size_valid = 1'b0;
    if (size > 11) merr = 1'b1;
    if (esize > 0) begin
      checks++;
      if ({size_ready, bit_ready, coeff_valid} !== 3'b010) begin
        errors++;
        $display("FAIL amp_flags got %b want 010", {size_ready, bit_ready, coeff_valid});
      end
      if (clr_mode == 2) begin
        pred_clear = 1'b1; tick(); pred_clear = 1'b0;
        model_clear();
      end
      for (int i = esize - 1; i >= 0; i--) begin
        if (gaps && $urandom_range(0, 1) == 1) begin
          tick();
          checks++;
          if (bit_ready !== 1'b1 || coeff_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_stall got bit_ready=%b coeff_valid=%b want 1 0", bit_ready, coeff_valid);
          end
        end
        bit_in = amp[i]; bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
      end
    end
    exp = model_coeff(mpred[ecomp], esize, amp);
    checks++;
    if ({size_ready, bit_ready, coeff_valid} !== 3'b001) begin
      errors++;
      $display("FAIL out_flags size=%0d got %b want 001", size, {size_ready, bit_ready, coeff_valid});
    end
    checks++;
    if (coeff_out !== exp) begin
      errors++;
      $display("FAIL coeff size=%0d comp=%0d amp=%0d got %0d want %0d", size, comp, amp, coeff_out, exp);
    end
    checks++;
    if (coeff_comp !== 2'(ecomp)) begin
      errors++;
      $display("FAIL coeff_comp got %0d want %0d", coeff_comp, ecomp);
    end
    checks++;
    if (size_err !== merr) begin
      errors++;
      $display("FAIL size_err got %b want %b", size_err, merr);
    end
    for (int k = 0; k < bp; k++) begin
      tick();
      checks++;
      if (coeff_valid !== 1'b1 || coeff_out !== exp || size_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure got valid=%b coeff=%0d size_ready=%b want 1 %0d 0",
                 coeff_valid, coeff_out, size_ready, exp);
      end
    end
    coeff_ready = 1'b1;
    if (clr_mode == 1) pred_clear = 1'b1;
    tick();
    coeff_ready = 1'b0; pred_clear = 1'b0;
    if (clr_mode == 1) model_clear();
    else mpred[ecomp] = exp;
    checks++;
    if ({size_ready, bit_ready, coeff_valid} !== 3'b100 || size_err !== merr) begin
      errors++;
      $display("FAIL post_hs got flags=%b size_err=%b want 100 %b",
               {size_ready, bit_ready, coeff_valid}, size_err, merr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    model_clear();
    checks++;
    if ({size_ready, bit_ready, coeff_valid, size_err} !== 4'b1000 ||
        coeff_out !== '0 || coeff_comp !== 2'd0) begin
      errors++;
      $display("FAIL reset got flags=%b err=%b coeff=%0d comp=%0d want 100 0 0 0",
               {size_ready, bit_ready, coeff_valid}, size_err, coeff_out, coeff_comp);
    end
  endtask

  task automatic test_size_zero();
    run_block(0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic test_basic();
    run_block(3, 0, 5, 1'b0, 0, 0);
    run_block(2, 0, 1, 1'b0, 0, 0);
  endtask

  task automatic test_interleave();
    run_block(1, 1, 0, 1'b0, 0, 0);
    run_block(1, 0, 1, 1'b0, 0, 0);
    run_block(1, 1, 1, 1'b0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_block(6, 2, 37, 1'b1, 5, 0);
    run_block(4, 2, 3, 1'b1, 2, 0);
  endtask

  task automatic test_wrap();
    pred_clear = 1'b1; tick(); pred_clear = 1'b0;
    model_clear();
    run_block(11, 0, 2047, 1'b0, 0, 0);
    run_block(11, 0, 2047, 1'b0, 0, 0);
  endtask

  task automatic test_size_err();
    run_block(13, 0, 0, 1'b0, 0, 0);
    run_block(0, 0, 0, 1'b0, 1, 1);
    run_block(0, 0, 0, 1'b0, 0, 0);
    run_block(3, 3, 6, 1'b0, 0, 0);
    run_block(5, 1, 9, 1'b0, 0, 2);
  endtask

  task automatic test_reset_mid();
    run_block(4, 1, 12, 1'b0, 0, 0);
    size_in = 4'd5; comp_in = 2'd1; size_valid = 1'b1; tick(); size_valid = 1'b0;
    bit_in = 1'b1; bit_valid = 1'b1; tick(); tick(); bit_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    model_clear();
    checks++;
    if ({size_ready, bit_ready, coeff_valid, size_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid got %b want 1000", {size_ready, bit_ready, coeff_valid, size_err});
    end
    run_block(0, 1, 0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int clr;
    for (int n = 0; n < 60; n++) begin
      clr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_block(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), clr);
    end
  endtask

  initial begin
    rst = 1'b1; size_in = '0; comp_in = '0; size_valid = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; pred_clear = 1'b0; coeff_ready = 1'b0;
    merr = 1'b0;
    test_reset();
    test_size_zero();
    test_basic();
    test_interleave();
    test_backpressure();
    test_wrap();
    test_size_err();
    test_random();
    test_reset_mid();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
